// File: rtl/four_bit_accumulator_pkg.sv
// Shared constants and types for the four-bit accumulator.
// The build macro ACC_SATURATE_EN is consumed in four_bit_accumulator.sv.
package four_bit_accumulator_pkg;

  localparam int ACC_WIDTH = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    RESULT = 1'b1
  } state_e;

  localparam logic [ACC_WIDTH-1:0] SAT_VALUE = 4'hF;

endpackage

// File: rtl/four_bit_parallel_adder.sv
// Purely combinational 4-bit ripple-carry adder: s = a + b + cin.
// Exposes the inter-stage carries c as well as the final carry-out.
module four_bit_parallel_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout,
  output logic [2:0] c
);

  logic [4:0] carryChain;

  assign carryChain[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_stage
    assign s[i]            = a[i] ^ b[i] ^ carryChain[i];
    assign carryChain[i+1] = (a[i] & b[i]) | (carryChain[i] & (a[i] ^ b[i]));
  end

  assign c    = carryChain[3:1];
  assign cout = carryChain[4];

endmodule

// File: rtl/four_bit_accumulator.sv
// Handshaked 4-bit accumulator with sticky overflow and an accepted-addition counter.
// Define ACC_SATURATE_EN to clamp acc to 4'hF whenever an addition carries out.
module four_bit_accumulator
  import four_bit_accumulator_pkg::*;
#(
  parameter int WIDTH = ACC_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] acc,
  output logic             carry,
  output logic             ovf,
  output logic [3:0]       count
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic [3:0]       count_q, count_d;

  logic [WIDTH-1:0] sum;
  logic             sumCout;
  logic [2:0]       unusedCarries;
  logic             accept;

  four_bit_parallel_adder u_adder (
    .a    (acc_q),
    .b    (b),
    .cin  (cin),
    .s    (sum),
    .cout (sumCout),
    .c    (unusedCarries)
  );

  assign accept = (state_q == IDLE) && in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      count_q <= count_d;
    end
  end

  // clear outranks both the input and output handshakes
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (in_valid)  state_d = RESULT;
        RESULT:  if (out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    acc_d   = acc_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    count_d = count_q;
    if (clear) begin
      acc_d   = '0;
      carry_d = 1'b0;
      ovf_d   = 1'b0;
      count_d = '0;
    end else if (accept) begin
`ifdef ACC_SATURATE_EN
      acc_d   = sumCout ? SAT_VALUE : sum;
`else
      acc_d   = sum;
`endif
      carry_d = sumCout;
      ovf_d   = ovf_q | sumCout;
      count_d = count_q + 4'd1;
    end
  end

  // Handshake outputs depend on registered state only
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == RESULT);
  end

  assign acc   = acc_q;
  assign carry = carry_q;
  assign ovf   = ovf_q;
  assign count = count_q;

endmodule

// File: tb/tb_four_bit_accumulator.sv
// Scoreboard bench for four_bit_accumulator; honours ACC_SATURATE_EN when defined.
module tb_four_bit_accumulator;

  typedef struct {
    logic [3:0] acc;
    logic       carry;
    logic [3:0] count;
    logic       ovf;
  } exp_t;

`ifdef ACC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, clear, in_valid, cin, out_ready;
  logic [3:0] b;
  logic       in_ready, out_valid, carry, ovf;
  logic [3:0] acc, count;

  exp_t       sbQueue[$];
  logic [3:0] modelAcc, modelCount;
  logic       modelOvf;
  int         compared   = 0;
  int         mismatched = 0;

  four_bit_accumulator #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc       (acc),
    .carry     (carry),
    .ovf       (ovf),
    .count     (count)
  );

  always #5 clk = ~clk;

  // Called at a negedge; offers one operand for exactly one rising edge
  task automatic applyStimulus(input logic [3:0] bVal, input logic cinVal);
    logic [4:0] s;
    exp_t e;
    in_valid = 1'b1;
    b        = bVal;
    cin      = cinVal;
    s = {1'b0, modelAcc} + {1'b0, bVal} + {4'b0, cinVal};
    modelAcc   = (SAT && s[4]) ? 4'hF : s[3:0];
    modelCount = modelCount + 4'd1;
    modelOvf   = modelOvf | s[4];
    e.acc = modelAcc; e.carry = s[4]; e.count = modelCount; e.ovf = modelOvf;
    sbQueue.push_back(e);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic releaseResult();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic resetModel();
    modelAcc = 4'd0; modelCount = 4'd0; modelOvf = 1'b0;
    sbQueue.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; b = 4'd0; cin = 1'b0;
    resetModel();
    repeat (2) @(negedge clk);
    compared++;
    if ({in_ready, out_valid, acc, carry, ovf, count} !== {1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0}) begin
      mismatched++;
      $display("[TB] FAIL reset_state got rdy=%b vld=%b acc=%h c=%b ovf=%b cnt=%0d want 1 0 0 0 0 0",
               in_ready, out_valid, acc, carry, ovf, count);
    end
  endtask

  task automatic test_accumulate();
    logic [3:0] opB[2]  = '{4'd3, 4'd5};
    logic       opC[2]  = '{1'b0, 1'b1};
    exp_t e;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(opB[i], opC[i]);
      e = sbQueue.pop_front();
      compared++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL accum_handshake[%0d] got vld=%b rdy=%b want 1 0", i, out_valid, in_ready);
      end
      compared++;
      if ({acc, carry, count, ovf} !== {e.acc, e.carry, e.count, e.ovf}) begin
        mismatched++;
        $display("[TB] FAIL accum_result[%0d] got acc=%h c=%b cnt=%0d ovf=%b want acc=%h c=%b cnt=%0d ovf=%b",
                 i, acc, carry, count, ovf, e.acc, e.carry, e.count, e.ovf);
      end
      if (i == 0) releaseResult();
    end
    in_valid = 1'b1; b = 4'd7; cin = 1'b1;
    repeat (3) @(negedge clk);
    compared++;
    if (acc !== 4'd9 || count !== 4'd2 || out_valid !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL result_hold got acc=%h cnt=%0d vld=%b want acc=9 cnt=2 vld=1", acc, count, out_valid);
    end
    in_valid = 1'b0;
    releaseResult();
    compared++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL release got rdy=%b vld=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_overflow();
    exp_t e;
    applyStimulus(4'd8, 1'b0);
    e = sbQueue.pop_front();
    compared++;
    if ({acc, carry, count, ovf} !== {e.acc, e.carry, e.count, e.ovf}) begin
      mismatched++;
      $display("[TB] FAIL overflow got acc=%h c=%b cnt=%0d ovf=%b want acc=%h c=%b cnt=%0d ovf=%b",
               acc, carry, count, ovf, e.acc, e.carry, e.count, e.ovf);
    end
    releaseResult();
  endtask

  task automatic test_clear();
    exp_t e;
    applyStimulus(4'd2, 1'b0);
    e = sbQueue.pop_front();
    compared++;
    if ({acc, carry, count, ovf, out_valid} !== {e.acc, e.carry, e.count, e.ovf, 1'b1}) begin
      mismatched++;
      $display("[TB] FAIL pre_clear got acc=%h c=%b cnt=%0d ovf=%b vld=%b want acc=%h c=%b cnt=%0d ovf=%b vld=1",
               acc, carry, count, ovf, out_valid, e.acc, e.carry, e.count, e.ovf);
    end
    clear = 1'b1; out_ready = 1'b1; in_valid = 1'b1; b = 4'd4;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    resetModel();
    compared++;
    if ({acc, carry, count, ovf, in_ready, out_valid} !== {4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL clear_priority got acc=%h c=%b cnt=%0d ovf=%b rdy=%b vld=%b want 0 0 0 0 1 0",
               acc, carry, count, ovf, in_ready, out_valid);
    end
  endtask

  task automatic test_count_wrap();
    exp_t e;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    resetModel();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(4'd0, 1'b0);
      e = sbQueue.pop_front();
      compared++;
      if ({acc, carry, count, ovf, out_valid} !== {e.acc, e.carry, e.count, e.ovf, 1'b1}) begin
        mismatched++;
        $display("[TB] FAIL wrap_step[%0d] got acc=%h c=%b cnt=%0d ovf=%b vld=%b want acc=%h c=%b cnt=%0d ovf=%b vld=1",
                 i, acc, carry, count, ovf, out_valid, e.acc, e.carry, e.count, e.ovf);
      end
      releaseResult();
    end
    compared++;
    if (count !== 4'd0 || acc !== 4'd0 || ovf !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL count_wrap got cnt=%0d acc=%h ovf=%b want 0 0 0", count, acc, ovf);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      e = sbQueue.pop_front();
      compared++;
      if ({acc, carry, count, ovf} !== {e.acc, e.carry, e.count, e.ovf}) begin
        mismatched++;
        $display("[TB] FAIL b2b[%0d] got acc=%h c=%b cnt=%0d ovf=%b want acc=%h c=%b cnt=%0d ovf=%b",
                 i, acc, carry, count, ovf, e.acc, e.carry, e.count, e.ovf);
      end
      releaseResult();
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    applyStimulus(4'd6, 1'b1);
    e = sbQueue.pop_front();
    compared++;
    if (out_valid !== 1'b1 || acc !== e.acc) begin
      mismatched++;
      $display("[TB] FAIL pre_async got vld=%b acc=%h want 1 %h", out_valid, acc, e.acc);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    compared++;
    if ({out_valid, in_ready, acc, count, ovf, carry} !== {1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL async_reset got vld=%b rdy=%b acc=%h cnt=%0d ovf=%b c=%b want 0 1 0 0 0 0",
               out_valid, in_ready, acc, count, ovf, carry);
    end
    @(negedge clk);
    rst_n = 1'b1;
    resetModel();
  endtask

  initial begin
    test_reset();
    test_accumulate();
    test_overflow();
    test_clear();
    test_count_wrap();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
